regfile_dump_reader: RTL and testbench

- Sequential reader for the register file's read port.
- On a start pulse it walks registers FIRST_REG..NUM_REGS-1 through one read port, captures each value, and streams (index, data) words out on a valid/ready interface.
- Used at end-of-simulation, alongside finish_flag, and by the debug path to dump architectural state without touching the core's own read ports.

---
 rtl/regfile_dump_reader_if.sv | 30 +++
 rtl/regfile_dump_reader.sv | 120 ++++++++++++
 tb/tb_regfile_dump_reader.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_dump_reader_if.sv
// Output stream of the register-file dump reader: one (index, data, last)
// word per valid/ready handshake.
interface regfile_dump_reader_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_index;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    // Producer side: the dump reader.
    modport master (
        output out_valid,
        output out_index,
        output out_data,
        output out_last,
        input  out_ready
    );

    // Consumer side: whoever collects the dumped state.
    modport slave (
        input  out_valid,
        input  out_index,
        input  out_data,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/regfile_dump_reader.sv
// Sequential register-file dump reader. On a start request in IDLE it walks
// registers FIRST_REG..NUM_REGS-1 through a single read port, captures each
// value in READ and presents it as a stream word in SEND until accepted.
// Every word costs two cycles (READ + SEND) with the consumer always ready.
module regfile_dump_reader #(
    parameter int NUM_REGS  = 32,
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 32,
    parameter int FIRST_REG = 0
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   start,
    output logic [ADDR_W-1:0]      rd_addr,
    input  logic [DATA_W-1:0]      rd_data,
    regfile_dump_reader_if.master  out_if,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(FIRST_REG);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W-1:0] IDX_ONE   = ADDR_W'(1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] index_q, index_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              last_q, last_d;
    logic [ADDR_W-1:0] rd_addr_s;
    logic              handshake_s;

    assign handshake_s = valid_q & out_if.out_ready;

    // State and output registers; synchronous reset abandons any dump in flight.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            valid_q <= 1'b0;
            index_q <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            index_q <= index_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    // Next-state logic: read address is driven only while capturing in READ.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        valid_d   = valid_q;
        index_d   = index_q;
        data_d    = data_q;
        last_d    = last_q;
        rd_addr_s = '0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    idx_d   = FIRST_IDX;
                    state_d = ST_READ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                rd_addr_s = idx_q;
                data_d    = rd_data;
                index_d   = idx_q;
                last_d    = (idx_q == LAST_IDX);
                valid_d   = 1'b1;
                state_d   = ST_SEND;
            end
            ST_SEND: begin
                if (handshake_s) begin
                    valid_d = 1'b0;
                    if (last_q) begin
                        state_d = ST_DONE;
                    end else begin
                        // Not last, so idx is below LAST_IDX and cannot wrap.
                        idx_d   = idx_q + IDX_ONE;
                        state_d = ST_READ;
                    end
                end else begin
                    state_d = ST_SEND;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    assign rd_addr          = rd_addr_s;
    assign busy             = (state_q != ST_IDLE);
    assign done             = (state_q == ST_DONE);
    assign out_if.out_valid = valid_q;
    assign out_if.out_index = index_q;
    assign out_if.out_data  = data_q;
    assign out_if.out_last  = last_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: a register-file array feeds two readers
// (FIRST_REG=0 and FIRST_REG=28); expected words are queued when a dump is
// requested and popped by monitors on every accepted word.
module tb_regfile_dump_reader;

    typedef struct {
        logic [4:0]  idx;
        logic [31:0] data;
        logic        last;
    } word_t;

    logic        clock;
    logic        reset_n;
    logic        start0, start1;
    logic [4:0]  rd_addr0, rd_addr1;
    logic [31:0] rd_data0, rd_data1;
    logic        busy0, busy1, done0_s, done1_s;

    logic [31:0] regs [32];
    word_t       exp_q0 [$];
    word_t       exp_q1 [$];
    word_t       w0, w1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int words0 = 0, words1 = 0;
    int done0 = 0, done1 = 0;
    int done_cyc0 = 0, done_cyc1 = 0;
    int start_cyc0 = 0, start_cyc1 = 0;

    regfile_dump_reader_if #(.ADDR_W(5), .DATA_W(32)) if0 ();
    regfile_dump_reader_if #(.ADDR_W(5), .DATA_W(32)) if1 ();

    regfile_dump_reader #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32), .FIRST_REG(0)) dut0 (
        .clock(clock), .reset_n(reset_n), .start(start0), .rd_addr(rd_addr0),
        .rd_data(rd_data0), .out_if(if0.master), .busy(busy0), .done(done0_s));

    regfile_dump_reader #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32), .FIRST_REG(28)) dut1 (
        .clock(clock), .reset_n(reset_n), .start(start1), .rd_addr(rd_addr1),
        .rd_data(rd_data1), .out_if(if1.master), .busy(busy1), .done(done1_s));

    assign rd_data0 = regs[rd_addr0];
    assign rd_data1 = regs[rd_addr1];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: required event not seen within bound", name);
    endtask

    // Monitor for reader 0: pops the scoreboard on every accepted word.
    always @(negedge clock) begin
        if (if0.out_valid && if0.out_ready) begin
            words0++;
            if (exp_q0.size() == 0) begin
                fail("r0_unexpected_word");
            end else begin
                w0 = exp_q0.pop_front();
                check("r0_index", if0.out_index, w0.idx);
                check("r0_data", if0.out_data, w0.data);
                check("r0_last", if0.out_last, w0.last);
            end
        end
        if (done0_s) begin
            done0++;
            done_cyc0 = cyc;
        end
    end

    // Monitor for reader 1 (FIRST_REG=28).
    always @(negedge clock) begin
        if (if1.out_valid && if1.out_ready) begin
            words1++;
            if (exp_q1.size() == 0) begin
                fail("r1_unexpected_word");
            end else begin
                w1 = exp_q1.pop_front();
                check("r1_index", if1.out_index, w1.idx);
                check("r1_data", if1.out_data, w1.data);
                check("r1_last", if1.out_last, w1.last);
            end
        end
        if (done1_s) begin
            done1++;
            done_cyc1 = cyc;
        end
    end

    // Reference model: a dump reports every register from first to 31 in order.
    task automatic push_dump0();
        for (int i = 0; i < 32; i++) exp_q0.push_back('{idx: 5'(i), data: regs[i], last: (i == 31)});
    endtask

    task automatic push_dump1();
        for (int i = 28; i < 32; i++) exp_q1.push_back('{idx: 5'(i), data: regs[i], last: (i == 31)});
    endtask

    task automatic start_dump0();
        push_dump0();
        @(posedge clock); #1 start0 = 1'b1;
        @(posedge clock); #1 start0 = 1'b0;
        start_cyc0 = cyc;
    endtask

    task automatic wait_done0(input int budget);
        int d;
        d = done0;
        for (int k = 0; k < budget && done0 == d; k++) @(posedge clock);
        if (done0 == d) fail("r0_done_timeout");
    endtask

    task automatic wait_valid0();
        for (int k = 0; k < 50; k++) begin
            @(negedge clock);
            if (if0.out_valid) break;
        end
        if (!if0.out_valid) fail("r0_valid_timeout");
    endtask

    task automatic accept_one0();
        wait_valid0();
        @(posedge clock); #1 if0.out_ready = 1'b1;
        @(posedge clock); #1 if0.out_ready = 1'b0;
    endtask

    task automatic randomize_regs();
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wb, db, dprev;
        reset_n = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        if0.out_ready = 1'b0;
        if1.out_ready = 1'b0;
        for (int i = 0; i < 32; i++) regs[i] = 32'h0;
        regs[3] = 32'hABCDEFFF;
        regs[5] = 32'hFBCDE111;

        // Reset state.
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_valid", if0.out_valid, 1'b0);
        check("rst_index", if0.out_index, 5'd0);
        check("rst_data", if0.out_data, 32'h0);
        check("rst_last", if0.out_last, 1'b0);
        check("rst_busy", busy0, 1'b0);
        check("rst_done", done0_s, 1'b0);
        check("rst_rd_addr", rd_addr0, 5'd0);
        @(posedge clock); #1 reset_n = 1'b1;

        // Full dump at full throughput with the preloaded pattern.
        if0.out_ready = 1'b1;
        wb = words0; db = done0;
        start_dump0();
        wait_done0(200);
        check("full_done_latency", done_cyc0 - start_cyc0, 64);
        check("full_words", words0 - wb, 32);
        check("full_done_pulses", done0 - db, 1);
        @(negedge clock);
        check("full_busy_after", busy0, 1'b0);
        check("full_done_dropped", done0_s, 1'b0);

        // Backpressure at index 3, then capture-only behaviour at index 5.
        if0.out_ready = 1'b0;
        wb = words0;
        start_dump0();
        repeat (3) accept_one0();
        wait_valid0();
        for (int k = 0; k < 7; k++) begin
            @(negedge clock);
            check("stall_valid", if0.out_valid, 1'b1);
            check("stall_index", if0.out_index, 5'd3);
            check("stall_data", if0.out_data, 32'hABCDEFFF);
        end
        @(posedge clock); #1 if0.out_ready = 1'b1;
        @(posedge clock); #1 if0.out_ready = 1'b0;
        check("stall_accept_once", words0 - wb, 4);
        wait_valid0();
        check("after_stall_index", if0.out_index, 5'd4);
        accept_one0();
        wait_valid0();
        check("r5_index", if0.out_index, 5'd5);
        regs[5] = 32'h12345678;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check("r5_data_held", if0.out_data, 32'hFBCDE111);
        end
        if0.out_ready = 1'b1;
        wait_done0(200);
        check("bp_words", words0 - wb, 32);
        regs[5] = 32'hFBCDE111;

        // start pulses during a running dump are ignored.
        wb = words0; db = done0;
        start_dump0();
        for (int k = 0; k < 100 && (words0 - wb) < 10; k++) @(posedge clock);
        #1 start0 = 1'b1;
        @(posedge clock); #1 start0 = 1'b0;
        for (int k = 0; k < 100 && (words0 - wb) < 20; k++) @(posedge clock);
        #1 start0 = 1'b1;
        @(posedge clock); #1 start0 = 1'b0;
        wait_done0(200);
        repeat (4) @(posedge clock);
        @(negedge clock);
        check("ign_words", words0 - wb, 32);
        check("ign_done_pulses", done0 - db, 1);
        check("ign_busy", busy0, 1'b0);

        // start held high: back-to-back dumps with random contents.
        randomize_regs();
        wb = words0;
        push_dump0();
        push_dump0();
        @(posedge clock); #1 start0 = 1'b1;
        @(posedge clock); #1 start_cyc0 = cyc;
        wait_done0(200);
        dprev = done_cyc0;
        check("held_first_latency", dprev - start_cyc0, 64);
        wait_done0(200);
        #1 start0 = 1'b0;
        check("held_second_gap", done_cyc0 - dprev, 66);
        check("held_words", words0 - wb, 64);

        // Random backpressure against random contents.
        for (int r = 0; r < 2; r++) begin
            randomize_regs();
            wb = words0; db = done0;
            if0.out_ready = 1'b0;
            start_dump0();
            for (int k = 0; k < 2000 && done0 == db; k++) begin
                if0.out_ready = 1'($urandom_range(0, 1));
                @(posedge clock); #1;
            end
            if (done0 == db) fail("rand_done_timeout");
            check("rand_words", words0 - wb, 32);
        end
        if0.out_ready = 1'b1;

        // Reset while presenting index 12.
        if0.out_ready = 1'b0;
        start_dump0();
        repeat (12) accept_one0();
        wait_valid0();
        check("pre_rst_index", if0.out_index, 5'd12);
        @(posedge clock); #1 reset_n = 1'b0;
        @(posedge clock); #1 reset_n = 1'b1;
        @(negedge clock);
        check("midrst_valid", if0.out_valid, 1'b0);
        check("midrst_index", if0.out_index, 5'd0);
        check("midrst_data", if0.out_data, 32'h0);
        check("midrst_last", if0.out_last, 1'b0);
        check("midrst_busy", busy0, 1'b0);
        check("midrst_done", done0_s, 1'b0);
        exp_q0.delete();
        if0.out_ready = 1'b1;
        wb = words0;
        start_dump0();
        wait_done0(200);
        check("post_rst_latency", done_cyc0 - start_cyc0, 64);
        check("post_rst_words", words0 - wb, 32);

        // Partial walk from FIRST_REG=28.
        if1.out_ready = 1'b1;
        push_dump1();
        @(posedge clock); #1 start1 = 1'b1;
        @(posedge clock); #1 start1 = 1'b0;
        start_cyc1 = cyc;
        for (int k = 0; k < 100 && done1 == 0; k++) @(posedge clock);
        if (done1 == 0) fail("r1_done_timeout");
        check("r1_done_latency", done_cyc1 - start_cyc1, 8);
        check("r1_words", words1, 4);
        @(negedge clock);
        check("r1_busy_after", busy1, 1'b0);

        check("r0_queue_empty", exp_q0.size(), 0);
        check("r1_queue_empty", exp_q1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
